// File: rtl/player_input_conditioner.sv
// Synchronises and debounces the four player-1 buttons, captures attack presses, and publishes exclusive commands on the game tick.
// Latency: 2 sync + DEBOUNCE_CYCLES clk to stable, then outputs update on the first i_tick at or after it; held until the next i_tick.
// Backpressure: none; extra attack presses within one tick period collapse into one and raise the sticky o_dropped flag.
module player_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_btn_left,
    input  logic i_btn_right,
    input  logic i_btn_attack,
    input  logic i_btn_dir_attack,
    output logic o_left,
    output logic o_right,
    output logic o_attack,
    output logic o_dir_attack,
    output logic o_dropped
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;
    localparam int CH_ATK   = 2;
    localparam int CH_DIR   = 3;

    logic [3:0] raw;
    logic [3:0] sync_meta;
    logic [3:0] sync;
    logic [3:0] stable;
    logic [3:0] stable_d;
    logic [3:0] rise;
    logic       pend_atk;
    logic       pend_dir;
    logic       atk_any;
    logic       dir_any;

    assign raw = {i_btn_dir_attack, i_btn_attack, i_btn_right, i_btn_left};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync      <= '0;
            stable_d  <= '0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
            stable_d  <= stable;
        end
    end

    // Any cycle where sync matches the accepted level restarts the count.
    for (genvar g = 0; g < 4; g++) begin : g_chan
        logic [CNT_WIDTH-1:0] cnt;
        logic                 stb;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
                stb <= 1'b0;
            end else if (sync[g] == stb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stb <= sync[g];
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end

        assign stable[g] = stb;
    end

    assign rise    = stable & ~stable_d;
    assign atk_any = pend_atk | rise[CH_ATK];
    assign dir_any = pend_dir | rise[CH_DIR];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_atk     <= 1'b0;
            pend_dir     <= 1'b0;
            o_left       <= 1'b0;
            o_right      <= 1'b0;
            o_attack     <= 1'b0;
            o_dir_attack <= 1'b0;
            o_dropped    <= 1'b0;
        end else begin
            if ((rise[CH_ATK] & pend_atk) | (rise[CH_DIR] & pend_dir))
                o_dropped <= 1'b1;
            if (i_tick) begin
                // A rise in the tick cycle is consumed here, never re-pended.
                o_left       <= stable[CH_LEFT] & ~stable[CH_RIGHT] & ~(atk_any | dir_any);
                o_right      <= stable[CH_RIGHT] & ~stable[CH_LEFT] & ~(atk_any | dir_any);
                o_dir_attack <= dir_any;
                o_attack     <= atk_any & ~dir_any;
                pend_atk     <= 1'b0;
                pend_dir     <= 1'b0;
                if (atk_any & dir_any)
                    o_dropped <= 1'b1;
            end else begin
                pend_atk <= atk_any;
                pend_dir <= dir_any;
            end
        end
    end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Directed bench for player_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_player_input_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_tick = 1'b0;
    logic i_btn_left = 1'b0;
    logic i_btn_right = 1'b0;
    logic i_btn_attack = 1'b0;
    logic i_btn_dir_attack = 1'b0;
    logic o_left, o_right, o_attack, o_dir_attack, o_dropped;

    int n_checks = 0;
    int n_pass = 0;

    always #10 clk = ~clk;

    player_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_tick(i_tick),
        .i_btn_left(i_btn_left),
        .i_btn_right(i_btn_right),
        .i_btn_attack(i_btn_attack),
        .i_btn_dir_attack(i_btn_dir_attack),
        .o_left(o_left),
        .o_right(o_right),
        .o_attack(o_attack),
        .o_dir_attack(o_dir_attack),
        .o_dropped(o_dropped)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_pulse();
        i_tick = 1'b1;
        step(1);
        i_tick = 1'b0;
    endtask

    initial begin
        // Reset with every button pressed and ticks running.
        i_btn_left = 1'b1;
        i_btn_right = 1'b1;
        i_btn_attack = 1'b1;
        i_btn_dir_attack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_tick = (i % 2 == 0);
            step(1);
            check("rst_outs", {3'b0, o_left, o_right, o_attack, o_dir_attack, o_dropped}, 8'h00);
        end
        i_tick = 1'b0;
        i_btn_left = 1'b0;
        i_btn_attack = 1'b0;
        i_btn_dir_attack = 1'b0;
        step(1);
        reset = 1'b0;
        step(5);
        i_tick = 1'b1;
        step(1);
        check("rst_early_tick", o_right, 1'b0);
        step(1);
        i_tick = 1'b0;
        check("rst_first_right", o_right, 1'b1);
        check("rst_no_cmd", {o_left, o_attack, o_dir_attack, o_dropped}, 4'h0);

        // Bounce rejection.
        i_btn_right = 1'b0;
        step(8);
        tick_pulse();
        check("right_released", o_right, 1'b0);
        for (int i = 0; i < 40; i++) begin
            i_btn_right = ((i / 2) % 2 == 0);
            i_tick = (i % 10 == 9);
            step(1);
            if (i % 10 == 9) check("bounce_right", o_right, 1'b0);
        end
        i_tick = 1'b0;
        i_btn_right = 1'b1;
        step(5);
        i_tick = 1'b1;
        step(1);
        check("hold_early_tick", o_right, 1'b0);
        step(1);
        i_tick = 1'b0;
        check("hold_right", o_right, 1'b1);

        // Mutual exclusion.
        i_btn_left = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step(19);
            tick_pulse();
            check("both_dirs", {o_left, o_right}, 2'b00);
        end
        i_btn_left = 1'b0;
        step(19);
        tick_pulse();
        check("left_release", {o_left, o_right}, 2'b01);
        i_btn_right = 1'b0;
        step(10);
        tick_pulse();
        check("dirs_idle", {o_left, o_right}, 2'b00);

        // Attack capture: one press between ticks.
        step(3);
        tick_pulse();
        i_btn_attack = 1'b1;
        step(8);
        i_btn_attack = 1'b0;
        step(12);
        tick_pulse();
        check("atk_pulse", o_attack, 1'b1);
        check("atk_no_drop", o_dropped, 1'b0);
        step(18);
        check("atk_held", o_attack, 1'b1);
        tick_pulse();
        check("atk_ends", o_attack, 1'b0);
        // Two presses in one window.
        i_btn_attack = 1'b1;
        step(8);
        i_btn_attack = 1'b0;
        step(8);
        i_btn_attack = 1'b1;
        step(8);
        i_btn_attack = 1'b0;
        step(10);
        tick_pulse();
        check("atk_double_one", o_attack, 1'b1);
        check("atk_double_drop", o_dropped, 1'b1);
        step(10);
        tick_pulse();
        check("atk_double_ends", o_attack, 1'b0);

        // Priority with rises coincident with the tick.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("drop_cleared", o_dropped, 1'b0);
        i_btn_right = 1'b1;
        step(10);
        tick_pulse();
        check("prio_pre_right", o_right, 1'b1);
        i_btn_attack = 1'b1;
        i_btn_dir_attack = 1'b1;
        step(6);
        tick_pulse();
        check("prio_dir", o_dir_attack, 1'b1);
        check("prio_atk", o_attack, 1'b0);
        check("prio_dirs_off", {o_left, o_right}, 2'b00);
        check("prio_drop", o_dropped, 1'b1);
        i_btn_attack = 1'b0;
        i_btn_dir_attack = 1'b0;
        step(10);
        tick_pulse();
        check("prio_after", {o_right, o_attack, o_dir_attack}, 3'b100);

        // Reset with an attack pending.
        i_btn_right = 1'b0;
        step(10);
        tick_pulse();
        i_btn_attack = 1'b1;
        step(8);
        i_btn_attack = 1'b0;
        step(8);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        tick_pulse();
        check("rstpend_atk", o_attack, 1'b0);
        check("rstpend_drop", o_dropped, 1'b0);
        step(10);
        tick_pulse();
        check("rstpend_quiet", {o_left, o_right, o_attack, o_dir_attack, o_dropped}, 5'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
